// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and oversampling constants,
// common to the receiver and the future transmitter.
package uart_pkg;

    localparam int DATA_BITS_DEF  = 8;
    localparam int OVERSAMPLE_DEF = 16;
    localparam int MID_SAMPLE     = 7;
    localparam int BIT_SAMPLE     = 15;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_t;

endpackage

// File: rtl/uart_sync_edge.sv
// Multi-flop synchroniser for an asynchronous level, with an optional
// single-cycle pulse on each rising edge of the synchronised signal.
module uart_sync_edge #(
    parameter int STAGES    = 2,
    parameter bit EDGE_EN   = 1'b1,
    parameter bit RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: flops preset to the idle level, so reset release never looks like an edge.
            sync_q <= {STAGES{RESET_VAL}};
        end else begin
            sync_q <= {sync_q[STAGES-2:0], din};
        end
    end

    assign level = sync_q[STAGES-1];

    generate
        if (EDGE_EN) begin : g_edge
            logic delay_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    delay_q <= RESET_VAL;
                end else begin
                    delay_q <= sync_q[STAGES-1];
                end
            end

            assign rise = sync_q[STAGES-1] & ~delay_q;
        end else begin : g_level
            assign rise = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/uart_receiver.sv
// 16x-oversampled UART receiver with valid/ack holding register, framing
// and overrun status. Define UART_RX_PARITY_EN to add an even-parity bit.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int DATA_BITS   = DATA_BITS_DEF,
    parameter int OVERSAMPLE  = OVERSAMPLE_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 sysclk,
    input  logic                 reset,
    input  logic                 brclk,
    input  logic                 rx,
    input  logic                 rx_ack,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_overrun,
    output logic                 rx_frame_err,
`ifdef UART_RX_PARITY_EN
    output logic                 rx_parity_err,
`endif
    output logic                 rx_busy
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);

    localparam logic [TW-1:0] MID_CNT  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] LAST_CNT = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    logic tick;
    logic rx_s;
    logic br_level_unused;
    logic rx_rise_unused;

    uart_state_t          state_q,    state_d;
    logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
    logic [BW-1:0]        bit_cnt_q,  bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q,    shift_d;
    logic                 stop_ok;
    logic                 stop_bad;
`ifdef UART_RX_PARITY_EN
    logic                 par_bad_q,  par_bad_d;
`endif

    uart_sync_edge #(
        .STAGES    (SYNC_STAGES),
        .EDGE_EN   (1'b1),
        .RESET_VAL (1'b1)
    ) u_brclk_sync (
        .clk   (sysclk),
        .rst_n (reset),
        .din   (brclk),
        .level (br_level_unused),
        .rise  (tick)
    );

    uart_sync_edge #(
        .STAGES    (SYNC_STAGES),
        .EDGE_EN   (1'b0),
        .RESET_VAL (1'b1)
    ) u_rx_sync (
        .clk   (sysclk),
        .rst_n (reset),
        .din   (rx),
        .level (rx_s),
        .rise  (rx_rise_unused)
    );

    always_comb begin
        // NOTE: every signal gets a default first, so no path can infer a latch.
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        stop_ok    = 1'b0;
        stop_bad   = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d  = par_bad_q;
`endif

        if (tick) begin
            unique case (state_q)
                IDLE: begin
                    if (!rx_s) begin
                        tick_cnt_d = '0;
                        state_d    = START;
                    end
                end

                START: begin
                    if (tick_cnt_q == MID_CNT) begin
                        tick_cnt_d = '0;
                        if (!rx_s) begin
                            bit_cnt_d = '0;
                            state_d   = DATA;
                        end else begin
                            state_d   = IDLE;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end

                DATA: begin
                    tick_cnt_d = tick_cnt_q + 1'b1;
                    if (tick_cnt_q == LAST_CNT) begin
                        shift_d   = {rx_s, shift_q[DATA_BITS-1:1]};
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        if (bit_cnt_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                            state_d = PARITY;
`else
                            state_d = STOP;
`endif
                        end
                    end
                end

`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    tick_cnt_d = tick_cnt_q + 1'b1;
                    if (tick_cnt_q == LAST_CNT) begin
                        par_bad_d = ^{shift_q, rx_s};
                        state_d   = STOP;
                    end
                end
`endif

                STOP: begin
                    tick_cnt_d = tick_cnt_q + 1'b1;
                    if (tick_cnt_q == LAST_CNT) begin
                        stop_ok  = rx_s;
                        stop_bad = ~rx_s;
                        state_d  = IDLE;
                    end
                end

                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
`ifdef UART_RX_PARITY_EN
            par_bad_q  <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking so every flop updates from pre-edge values.
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
`ifdef UART_RX_PARITY_EN
            par_bad_q  <= par_bad_d;
`endif
        end
    end

    // Holding register: a completing frame takes priority over the ack,
    // and an ack in that same cycle only suppresses the overrun.
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            rx_data       <= '0;
            rx_valid      <= 1'b0;
            rx_overrun    <= 1'b0;
            rx_frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            rx_parity_err <= 1'b0;
`endif
        end else begin
            rx_frame_err <= stop_bad;
`ifdef UART_RX_PARITY_EN
            rx_parity_err <= (stop_ok | stop_bad) & par_bad_q;
`endif
            if (stop_ok) begin
                rx_data  <= shift_q;
                rx_valid <= 1'b1;
                if (rx_valid && !rx_ack) begin
                    rx_overrun <= 1'b1;
                end else if (rx_valid && rx_ack) begin
                    rx_overrun <= 1'b0;
                end
            end else if (rx_ack && rx_valid) begin
                rx_valid   <= 1'b0;
                rx_overrun <= 1'b0;
            end
        end
    end

    assign rx_busy = (state_q != IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: table of whole frames plus hand-written
// glitch, simultaneous-ack and mid-frame reset sequences.
`timescale 1ns/1ps
module tb_uart_receiver;

    // brclk half-period scaled down from the real 326 so frames stay short;
    // all frame timing below derives from it.
    localparam int BR_HALF   = 8;
    localparam int TICK_CYC  = 2 * BR_HALF;
    localparam int BIT_CYC   = 16 * TICK_CYC;
    localparam int STOP_TICK = 152;   // start-detect tick is tick 0
    localparam int WAIT_MAX  = 200 * TICK_CYC;

    logic       sysclk = 1'b0;
    logic       reset  = 1'b0;
    logic       brclk  = 1'b0;
    logic       rx     = 1'b1;
    logic       rx_ack = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_overrun;
    logic       rx_frame_err;
    logic       rx_busy;

    int n_checks = 0;
    int n_fail   = 0;
    int ferr_cnt = 0;
    int ferr_base;

    logic       s_ok;
    logic       s_valid_at;
    logic       s_valid_next;
    logic [7:0] s_data_next;
    logic       s_ovr_next;
    logic       s_ferr_next;

    uart_receiver dut (
        .sysclk       (sysclk),
        .reset        (reset),
        .brclk        (brclk),
        .rx           (rx),
        .rx_ack       (rx_ack),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_overrun   (rx_overrun),
        .rx_frame_err (rx_frame_err),
        .rx_busy      (rx_busy)
    );

    always #5 sysclk = ~sysclk;

    initial begin
        forever begin
            repeat (BR_HALF) @(negedge sysclk);
            brclk = ~brclk;
        end
    end

    // Timing reference: when the receiver should see a tick and the line.
    logic [1:0] m_br;
    logic       m_br_d;
    logic [1:0] m_rx;
    logic       m_tick;

    always @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            m_br   <= 2'b11;
            m_br_d <= 1'b1;
            m_rx   <= 2'b11;
        end else begin
            m_br   <= {m_br[0], brclk};
            m_br_d <= m_br[1];
            m_rx   <= {m_rx[0], rx};
        end
    end

    assign m_tick = m_br[1] & ~m_br_d;

    always @(negedge sysclk) begin
        if (rx_frame_err === 1'b1) ferr_cnt++;
    end

    typedef struct packed {
        logic [7:0] data;
        logic       stop_bit;
        logic       ack_after;
        logic       exp_valid_before;
        logic [7:0] exp_data;
        logic       exp_valid;
        logic       exp_ferr;
        logic       exp_ovr;
    } frame_vec_t;

    frame_vec_t vecs [4];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit);
        rx = 1'b0;
        repeat (BIT_CYC) @(negedge sysclk);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (BIT_CYC) @(negedge sysclk);
        end
        rx = stop_bit;
        repeat (BIT_CYC) @(negedge sysclk);
        rx = 1'b1;
    endtask

    // Follows the frame tick by tick and captures the outputs around the
    // stop-sample tick; optionally acks in exactly that cycle.
    task automatic wait_stop(input logic ack_at_stop);
        int  n       = 0;
        bit  started = 1'b0;
        s_ok = 1'b0;
        for (int c = 0; c < WAIT_MAX; c++) begin
            if (m_tick) begin
                if (!started) begin
                    if (!m_rx[1]) started = 1'b1;
                end else begin
                    n++;
                end
                if (started && n == STOP_TICK) begin
                    s_ok = 1'b1;
                    break;
                end
            end
            @(negedge sysclk);
        end
        s_valid_at = rx_valid;
        if (ack_at_stop) rx_ack = 1'b1;
        @(negedge sysclk);
        rx_ack       = 1'b0;
        s_valid_next = rx_valid;
        s_data_next  = rx_data;
        s_ovr_next   = rx_overrun;
        s_ferr_next  = rx_frame_err;
    endtask

    task automatic run_frame(input logic [7:0] d, input logic stop_bit, input logic ack_at_stop);
        ferr_base = ferr_cnt;
        fork
            send_frame(d, stop_bit);
            wait_stop(ack_at_stop);
        join
        check($sformatf("frame_%02h stop_tick_seen", d), 16'(s_ok), 16'd1);
        repeat (2 * BIT_CYC) @(negedge sysclk);
    endtask

    task automatic pulse_ack();
        rx_ack = 1'b1;
        @(negedge sysclk);
        rx_ack = 1'b0;
    endtask

    initial begin
        vecs[0] = '{8'h55, 1'b1, 1'b1, 1'b0, 8'h55, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{8'hA3, 1'b0, 1'b0, 1'b0, 8'h55, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{8'h12, 1'b1, 1'b0, 1'b0, 8'h12, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{8'h34, 1'b1, 1'b1, 1'b1, 8'h34, 1'b1, 1'b0, 1'b1};

        repeat (4) @(negedge sysclk);
        check("reset rx_data",      16'(rx_data),      16'h0);
        check("reset rx_valid",     16'(rx_valid),     16'h0);
        check("reset rx_overrun",   16'(rx_overrun),   16'h0);
        check("reset rx_frame_err", 16'(rx_frame_err), 16'h0);
        check("reset rx_busy",      16'(rx_busy),      16'h0);
        reset = 1'b1;
        repeat (3 * TICK_CYC) @(negedge sysclk);

        for (int i = 0; i < 4; i++) begin
            run_frame(vecs[i].data, vecs[i].stop_bit, 1'b0);
            check($sformatf("v%0d valid_before", i), 16'(s_valid_at),   16'(vecs[i].exp_valid_before));
            check($sformatf("v%0d valid", i),        16'(s_valid_next), 16'(vecs[i].exp_valid));
            check($sformatf("v%0d data", i),         16'(s_data_next),  16'(vecs[i].exp_data));
            check($sformatf("v%0d ferr_pulse", i),   16'(s_ferr_next),  16'(vecs[i].exp_ferr));
            check($sformatf("v%0d overrun", i),      16'(s_ovr_next),   16'(vecs[i].exp_ovr));
            check($sformatf("v%0d ferr_count", i),   16'(ferr_cnt - ferr_base), 16'(vecs[i].exp_ferr));
            check($sformatf("v%0d busy_after", i),   16'(rx_busy),      16'h0);
            if (vecs[i].ack_after) begin
                pulse_ack();
                check($sformatf("v%0d valid_after_ack", i),   16'(rx_valid),   16'h0);
                check($sformatf("v%0d overrun_after_ack", i), 16'(rx_overrun), 16'h0);
            end
        end

        // Short low glitch on an idle line.
        ferr_base = ferr_cnt;
        rx = 1'b0;
        repeat (3 * TICK_CYC) @(negedge sysclk);
        rx = 1'b1;
        repeat (TICK_CYC) @(negedge sysclk);
        check("glitch busy_in_start", 16'(rx_busy), 16'h1);
        repeat (8 * TICK_CYC) @(negedge sysclk);
        check("glitch busy_dropped", 16'(rx_busy),  16'h0);
        check("glitch valid",        16'(rx_valid), 16'h0);
        check("glitch ferr_count",   16'(ferr_cnt - ferr_base), 16'h0);

        // Ack with nothing pending is ignored.
        pulse_ack();
        check("idle_ack valid", 16'(rx_valid), 16'h0);
        check("idle_ack data",  16'(rx_data),  16'h34);

        // Ack lands in the same cycle a new frame completes.
        run_frame(8'h12, 1'b1, 1'b0);
        check("pend12 valid", 16'(s_valid_next), 16'h1);
        check("pend12 data",  16'(s_data_next),  16'h12);
        run_frame(8'h7E, 1'b1, 1'b1);
        check("simul valid_before", 16'(s_valid_at),   16'h1);
        check("simul valid",        16'(s_valid_next), 16'h1);
        check("simul data",         16'(s_data_next),  16'h7E);
        check("simul overrun",      16'(s_ovr_next),   16'h0);

        // Reset in the middle of bit 4 of 0xF0.
        fork
            send_frame(8'hF0, 1'b1);
            begin
                repeat (5 * BIT_CYC + BIT_CYC / 2) @(negedge sysclk);
                check("midreset busy_before", 16'(rx_busy), 16'h1);
                #2 reset = 1'b0;
                #1;
                check("midreset rx_data",      16'(rx_data),      16'h0);
                check("midreset rx_valid",     16'(rx_valid),     16'h0);
                check("midreset rx_overrun",   16'(rx_overrun),   16'h0);
                check("midreset rx_frame_err", 16'(rx_frame_err), 16'h0);
                check("midreset rx_busy",      16'(rx_busy),      16'h0);
                repeat (4) @(negedge sysclk);
                reset = 1'b1;
            end
        join
        repeat (2 * BIT_CYC) @(negedge sysclk);
        check("post_reset valid_idle", 16'(rx_valid), 16'h0);

        run_frame(8'h0F, 1'b1, 1'b0);
        check("post_reset valid_before", 16'(s_valid_at),   16'h0);
        check("post_reset valid",        16'(s_valid_next), 16'h1);
        check("post_reset data",         16'(s_data_next),  16'h0F);
        check("post_reset overrun",      16'(s_ovr_next),   16'h0);
        check("post_reset ferr_count",   16'(ferr_cnt - ferr_base), 16'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
- 8N1 UART receive stage sitting directly downstream of the baud-rate generator.
- Consumes the 9600×16 Hz `brclk` as a 16× oversampling tick and samples the asynchronous `rx` pin.
- Delivers received bytes to the peripheral bus through a valid/ack holding register, with framing and overrun status.
- Everything runs on `sysclk`; `brclk` is never used as a clock.

Parameters:
- DATA_BITS, 8, payload bits per frame, LSB first.
- OVERSAMPLE, 16, brclk ticks per bit period.
- SYNC_STAGES, 2, flip-flops in the `rx` and `brclk` synchronisers (minimum 2).

Ports:
- sysclk  input  1  system clock, 100 MHz.
- reset  input  1  asynchronous, active-low reset.
- brclk  input  1  16× baud square wave from the baud-rate generator.
- rx  input  1  serial line, idle high, asynchronous to sysclk.
- rx_ack  input  1  one-cycle pulse; the consumer has taken `rx_data`.
- rx_data  output  DATA_BITS  last received byte.
- rx_valid  output  1  high while `rx_data` holds an unconsumed byte.
- rx_overrun  output  1  sticky; a byte was overwritten before it was acked.
- rx_frame_err  output  1  one-cycle pulse; stop bit sampled low.
- rx_busy  output  1  high while the FSM is not IDLE.

Behaviour:
- Reset values:
  - All outputs 0.
  - FSM in IDLE; tick and bit counters 0.
  - Synchroniser flops preset to 1, so no false start bit is seen.
- Tick generation:
  - `brclk` passes through SYNC_STAGES flops, then one extra flop.
  - tick = synced & ~delayed, i.e. a single-sysclk pulse per brclk rising edge.
- Line input: `rx` passes through SYNC_STAGES flops.
- Counters:
  - 4-bit tick_cnt wraps 15→0.
  - 3-bit bit_cnt wraps 7→0.
  - Both advance only on tick.
- FSM (transitions evaluated only on tick cycles unless noted):
  - IDLE: when rx_s == 0 on a tick, clear tick_cnt and go to START.
  - START: on tick, tick_cnt++. At tick_cnt == 7 (mid-bit): if rx_s == 0, clear tick_cnt and bit_cnt and go to DATA. Otherwise the low was a glitch; return to IDLE.
  - DATA: tick_cnt++. At tick_cnt == 15, shift rx_s into shift[DATA_BITS-1] (shift right, LSB first) and increment bit_cnt. After the DATA_BITS-th sample go to STOP.
  - STOP: tick_cnt++. At tick_cnt == 15 (mid-stop), sample rx_s.
    - If 1: the next sysclk loads rx_data from shift and sets rx_valid.
    - If 0: pulse rx_frame_err for one cycle; rx_data and rx_valid are unchanged.
    - Either way go to IDLE, so resync is ready from mid-stop.
- Latency: rx_valid rises exactly 1 sysclk after the tick that samples the stop bit.
- Handshake:
  - rx_ack with rx_valid == 1 clears rx_valid on the next cycle.
  - rx_ack while rx_valid == 0 is ignored.
- Overrun:
  - A good frame completes while rx_valid == 1 and no ack arrives in the same cycle: rx_data is overwritten, rx_valid stays 1, and rx_overrun is set.
  - rx_overrun clears on the next rx_ack.
- Simultaneous ack and completion: the new byte loads, rx_valid stays 1, rx_overrun is not set.
- rx stuck low (break): it frames as 0x00 with frame_err. The FSM then re-enters START on the next tick and repeats while the line stays low.
- Reset mid-frame: immediate abort to IDLE; the partial byte is discarded.

Optional Feature:
- UART_RX_PARITY_EN:
  - When defined, a PARITY state sits between DATA and STOP and samples one even-parity bit at tick_cnt == 15.
  - A mismatch pulses an extra output `rx_parity_err` (1 bit) in the same cycle the frame completes. The byte is still delivered to rx_data.
  - When undefined, there is no PARITY state and no `rx_parity_err` port (8N1 only).

Decomposition:
- Shared package `uart_pkg`:
  - FSM state encoding: IDLE, START, DATA, PARITY, STOP.
  - Constants OVERSAMPLE_DEF = 16, MID_SAMPLE = 7, BIT_SAMPLE = 15.
  - Default DATA_BITS; shared with the future uart_transmitter.
- One sub-module, `uart_sync_edge`: an SYNC_STAGES flop synchroniser with an optional rising-edge pulse output. It is instantiated twice, once for brclk (edge used) and once for rx (level only).

Test Plan:
- Timing basis: drive brclk from a model toggling every 326 sysclk cycles, giving a 652-cycle tick. One bit is 16 ticks = 10432 sysclk cycles.
- Reset, then send 0x55 as 8N1 → rx_data = 0x55 and rx_valid = 1 one cycle after the stop-sample tick. rx_frame_err and rx_overrun stay 0. Then rx_ack → rx_valid = 0 next cycle.
- 3-tick low glitch on an idle line → FSM returns to IDLE at START mid-sample; rx_valid stays 0 and rx_busy drops.
- Send 0xA3 with the stop bit held 0 → rx_frame_err pulses once; rx_valid and rx_data keep their prior values.
- Send 0x12 then 0x34 with no ack → rx_data = 0x34, rx_valid = 1, rx_overrun = 1. rx_ack clears both.
- Assert rx_ack in the same cycle 0x7E completes, with 0x12 still pending → rx_data = 0x7E, rx_valid = 1, rx_overrun = 0.
- Pull reset low in the middle of bit 4 of 0xF0 → all outputs 0 immediately. After release, the next full frame 0x0F is received correctly.
